dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the MEM pipeline stage (EX/MEM register outputs: address, store data, MemRead, MemWrite) and a slow, handshaked main data memory.
- Hits complete in the same cycle.
- Misses assert stall_o, which freezes PC and all pipeline registers until the access resolves.

---
 rtl/cpu_mem_pkg.sv | 20 ++
 rtl/dcache_sram.sv | 57 +++++
 rtl/dcache_controller.sv | 209 ++++++++++++++++++++
 tb/tb_dcache_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared constants and FSM encoding for the L1 data cache.
// Address-field widths are derived from the default cache geometry.
package cpu_mem_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_NUM_LINES  = 32;
    localparam int unsigned DEF_LINE_BYTES = 32;

    localparam int unsigned OFFSET_W = $clog2(DEF_LINE_BYTES);
    localparam int unsigned INDEX_W  = $clog2(DEF_NUM_LINES);
    localparam int unsigned TAG_W    = DEF_ADDR_W - OFFSET_W - INDEX_W;
    localparam int unsigned LINE_W   = DEF_LINE_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } dcache_state_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the direct-mapped cache: one combinational
// read port and one synchronous full-line write port sharing a single index.
module dcache_sram #(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned INDEX_W   = 5,
    parameter int unsigned TAG_W     = 22,
    parameter int unsigned LINE_W    = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] index_i,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [LINE_W-1:0]  rd_data_o,
    input  logic               we_i,
    input  logic               wr_valid_i,
    input  logic               wr_dirty_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [LINE_W-1:0]  wr_data_i
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid_o = valid_q[index_i];
    assign rd_dirty_o = dirty_q[index_i];
    assign rd_tag_o   = tag_q[index_i];
    assign rd_data_o  = data_q[index_i];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (we_i) begin
            valid_d[index_i] = wr_valid_i;
            dirty_d[index_i] = wr_dirty_i;
        end
    end

    // Only the status bits are reset; tag and data are don't-care while invalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            if (we_i) begin
                tag_q[index_i]  <= wr_tag_i;
                data_q[index_i] <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// Define DCACHE_STATS_EN to add saturating hit/miss counters (hit_count_o, miss_count_o).
module dcache_controller
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
    parameter int unsigned LINE_BYTES = DEF_LINE_BYTES
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_W-1:0]       cpu_addr_i,
    input  logic [31:0]             cpu_data_i,
    input  logic                    cpu_read_i,
    input  logic                    cpu_write_i,
    output logic [31:0]             cpu_data_o,
    output logic                    stall_o,
    output logic                    mem_enable_o,
    output logic                    mem_write_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [LINE_BYTES*8-1:0] mem_data_o,
    input  logic [LINE_BYTES*8-1:0] mem_data_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]             hit_count_o,
    output logic [31:0]             miss_count_o,
`endif
    input  logic                    mem_ack_i
);

    localparam int unsigned OFF_W     = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W     = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS  = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned LINE_BITS = LINE_BYTES * 8;
    localparam int unsigned SH_W      = OFF_W + 3;
    localparam logic [SH_W-1:0] WORD_MASK = ~SH_W'(31);

    logic [OFF_W-1:0]     cpu_off;
    logic [IDX_W-1:0]     cpu_index;
    logic [TAG_BITS-1:0]  cpu_tag;
    logic [SH_W-1:0]      word_sh;
    logic                 req, hit;

    logic                 rd_valid, rd_dirty;
    logic [TAG_BITS-1:0]  rd_tag;
    logic [LINE_BITS-1:0] rd_data;
    logic [LINE_BITS-1:0] merged_line;

    logic                 sram_we, wr_valid, wr_dirty;
    logic [LINE_BITS-1:0] wr_data;

    dcache_state_t        state_q, state_d;
    logic                 mem_enable_q, mem_enable_d;
    logic                 mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

    assign cpu_off   = cpu_addr_i[OFF_W-1:0];
    assign cpu_index = cpu_addr_i[OFF_W +: IDX_W];
    assign cpu_tag   = cpu_addr_i[ADDR_W-1 -: TAG_BITS];

    // Bit offset of the selected 32-bit word; byte-within-word bits are masked off.
    assign word_sh = {cpu_off, 3'b000} & WORD_MASK;

    assign req = cpu_read_i | cpu_write_i;
    assign hit = req & rd_valid & (rd_tag == cpu_tag);

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (IDX_W),
        .TAG_W     (TAG_BITS),
        .LINE_W    (LINE_BITS)
    ) u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .index_i    (cpu_index),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (sram_we & ~rst_i),
        .wr_valid_i (wr_valid),
        .wr_dirty_i (wr_dirty),
        .wr_tag_i   (cpu_tag),
        .wr_data_i  (wr_data)
    );

    always_comb begin
        merged_line = rd_data;
        merged_line[word_sh +: 32] = cpu_data_i;
    end

    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        sram_we      = 1'b0;
        wr_valid     = 1'b1;
        wr_dirty     = 1'b1;
        wr_data      = merged_line;
        unique case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    mem_enable_d = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d     = WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {rd_tag, cpu_index, {OFF_W{1'b0}}};
                        mem_data_d  = rd_data;
                    end else begin
                        state_d     = REFILL;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {cpu_tag, cpu_index, {OFF_W{1'b0}}};
                    end
                end else if (cpu_write_i && hit) begin
                    sram_we = 1'b1;
                end
            end
            WRITEBACK: begin
                if (mem_enable_q && mem_ack_i) begin
                    state_d      = REFILL;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                end
            end
            REFILL: begin
                // Entered from WRITEBACK with enable low; raise the refill request next.
                if (!mem_enable_q) begin
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = {cpu_tag, cpu_index, {OFF_W{1'b0}}};
                end else if (mem_ack_i) begin
                    state_d      = IDLE;
                    mem_enable_d = 1'b0;
                    sram_we      = 1'b1;
                    wr_dirty     = 1'b0;
                    wr_data      = mem_data_i;
                end
            end
            default: begin
                state_d      = IDLE;
                mem_enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    assign stall_o    = (req & ~hit) | (state_q != IDLE);
    assign cpu_data_o = (state_q == IDLE && hit) ? rd_data[word_sh +: 32] : 32'h0;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        refill_done_q, refill_done_d;

    // The hit that completes a refilled access belongs to the miss already counted.
    always_comb begin
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        refill_done_d = (state_q == REFILL) && (state_d == IDLE);
        if (state_q == IDLE && req) begin
            if (hit) begin
                if (!refill_done_q && hit_count_q != 32'hFFFF_FFFF) begin
                    hit_count_d = hit_count_q + 32'd1;
                end
            end else if (miss_count_q != 32'hFFFF_FFFF) begin
                miss_count_d = miss_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_count_q   <= '0;
            miss_count_q  <= '0;
            refill_done_q <= 1'b0;
        end else begin
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
            refill_done_q <= refill_done_d;
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios followed by random
// accesses, checked against a flat CPU-visible memory image and per-index tag model.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i, cpu_data_i;
    logic         cpu_read_i, cpu_write_i;
    logic [31:0]  cpu_data_o;
    logic         stall_o, mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count_o, miss_count_o;
`endif

    always #5 clk = ~clk;

    dcache_controller u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_read_i   (cpu_read_i),
        .cpu_write_i  (cpu_write_i),
        .cpu_data_o   (cpu_data_o),
        .stall_o      (stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
`ifdef DCACHE_STATS_EN
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o),
`endif
        .mem_ack_i    (mem_ack_i)
    );

    int checks = 0;
    int failures = 0;
    int exp_hits, exp_misses;

    // Reference state: what the CPU should see, what main memory holds, and
    // which line each index currently caches.
    logic [31:0] shadow    [logic [31:0]];
    logic [31:0] mem_words [logic [31:0]];
    bit          m_valid [32];
    bit          m_dirty [32];
    logic [21:0] m_tag   [32];

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] wa);
        return shadow.exists(wa) ? shadow[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        return mem_words.exists(wa) ? mem_words[wa] : init_word(wa);
    endfunction

    function automatic logic [255:0] shadow_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = shadow_rd((la >> 2) + w);
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_rd((la >> 2) + w);
        return l;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset drops every cached line, so the CPU view falls back to main memory.
    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        shadow.delete();
        foreach (mem_words[k]) shadow[k] = mem_words[k];
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i       = 1'b1;
        cpu_read_i  = 1'b0;
        cpu_write_i = 1'b0;
        mem_ack_i   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", stall_o, 1'b0);
        check("rst_enable", mem_enable_o, 1'b0);
        check("rst_write", mem_write_o, 1'b0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_data", mem_data_o, 256'h0);
        check("rst_cpu_data", cpu_data_o, 32'h0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_count", hit_count_o, 32'h0);
        check("rst_miss_count", miss_count_o, 32'h0);
`endif
        rst_i = 1'b0;
        model_reset();
    endtask

    // Serve one memory request; returns in the cycle after the ack.
    task automatic mem_txn(input logic is_wb, input logic [31:0] exp_addr,
                           input logic [255:0] exp_data, input int dly);
        for (int i = 0; i < 8 && mem_enable_o !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        check("mem_enable_raise", mem_enable_o, 1'b1);
        check("mem_write_kind", mem_write_o, is_wb);
        check("mem_addr", mem_addr_o, exp_addr);
        if (is_wb) check("wb_line_data", mem_data_o, exp_data);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            #1;
            check("hold_enable", mem_enable_o, 1'b1);
            check("hold_addr", mem_addr_o, exp_addr);
            check("hold_stall", stall_o, 1'b1);
        end
        @(negedge clk);
        if (is_wb) begin
            for (int w = 0; w < 8; w++) mem_words[(exp_addr >> 2) + w] = mem_data_o[w*32 +: 32];
        end else begin
            mem_data_i = mem_line(exp_addr);
        end
        mem_ack_i = 1'b1;
        #1;
        check("ack_cycle_stall", stall_o, 1'b1);
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        check("ack_gap_enable", mem_enable_o, 1'b0);
        if (is_wb) check("wb_gap_stall", stall_o, 1'b1);
    endtask

    task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                          input logic wr, input int wb_dly, input int rf_dly);
        logic [4:0]  idx;
        logic [21:0] tg;
        logic [31:0] wa, la, vla, old_word;
        bit          exp_hit, exp_wb;
        idx      = addr[9:5];
        tg       = addr[31:10];
        wa       = addr >> 2;
        la       = {addr[31:5], 5'b0};
        vla      = {m_tag[idx], idx, 5'b0};
        exp_hit  = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb   = !exp_hit && m_valid[idx] && m_dirty[idx];
        old_word = shadow_rd(wa);
        @(negedge clk);
        cpu_addr_i  = addr;
        cpu_data_i  = wdata;
        cpu_read_i  = rd;
        cpu_write_i = wr;
        #1;
        check("stall_on_request", stall_o, !exp_hit);
        if (exp_hit) begin
            exp_hits++;
            if (rd) check("hit_read_data", cpu_data_o, old_word);
            mem_ack_i = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
        end else begin
            exp_misses++;
            check("miss_idle_enable", mem_enable_o, 1'b0);
            if (exp_wb) mem_txn(1'b1, vla, shadow_line(vla), wb_dly);
            mem_txn(1'b0, la, 256'h0, rf_dly);
            check("post_refill_stall", stall_o, 1'b0);
            if (rd) check("miss_read_data", cpu_data_o, old_word);
            @(posedge clk);
            #1;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        if (wr) begin
            shadow[wa]   = wdata;
            m_dirty[idx] = 1'b1;
        end
        cpu_read_i  = 1'b0;
        cpu_write_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        rst_i       = 1'b1;
        cpu_addr_i  = '0;
        cpu_data_i  = '0;
        cpu_read_i  = 1'b0;
        cpu_write_i = 1'b0;
        mem_data_i  = '0;
        mem_ack_i   = 1'b0;
        do_reset();
        mem_words[32'h11] = 32'hDEAD_BEEF;
        shadow[32'h11]    = 32'hDEAD_BEEF;

        access(32'h0000_0044, 32'h0, 1'b1, 1'b0, 0, 0);
        access(32'h0000_0044, 32'h1234_5678, 1'b0, 1'b1, 0, 0);
        access(32'h0000_0044, 32'h0, 1'b1, 1'b0, 0, 0);
        access(32'h0000_0444, 32'h0, 1'b1, 1'b0, 2, 1);
        check("wb_word1_in_memory", mem_words[32'h11], 32'h1234_5678);
        access(32'h0000_1000, 32'h0, 1'b1, 1'b0, 0, 10);
        access(32'h0000_0048, 32'hCAFE_F00D, 1'b1, 1'b1, 3, 2);

        // Reset lands in the same cycle as the refill ack.
        @(negedge clk);
        cpu_addr_i = 32'h0000_0880;
        cpu_read_i = 1'b1;
        #1;
        check("midmiss_stall", stall_o, 1'b1);
        for (int i = 0; i < 8 && mem_enable_o !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        check("midmiss_enable", mem_enable_o, 1'b1);
        check("midmiss_addr", mem_addr_o, 32'h0000_0880);
        @(negedge clk);
        rst_i      = 1'b1;
        mem_ack_i  = 1'b1;
        mem_data_i = {8{32'h5555_AAAA}};
        @(negedge clk);
        rst_i      = 1'b0;
        mem_ack_i  = 1'b0;
        cpu_read_i = 1'b0;
        #1;
        check("midmiss_enable_after_rst", mem_enable_o, 1'b0);
        check("midmiss_stall_after_rst", stall_o, 1'b0);
        model_reset();
`ifdef DCACHE_STATS_EN
        check("midmiss_hit_count", hit_count_o, 32'h0);
        check("midmiss_miss_count", miss_count_o, 32'h0);
`endif
        access(32'h0000_0880, 32'h0, 1'b1, 1'b0, 0, 1);
        access(32'h0000_0880, 32'h0, 1'b1, 1'b0, 0, 0);
        access(32'h0000_0884, 32'h0BAD_F00D, 1'b0, 1'b1, 0, 0);
        access(32'h0000_0884, 32'h0, 1'b1, 1'b0, 0, 0);
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        #1;
        check("stats_hit_count", hit_count_o, exp_hits);
        check("stats_miss_count", miss_count_o, exp_misses);
`endif

        for (int n = 0; n < 300; n++) begin
            a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom & 31);
            op = $urandom_range(0, 2);
            access(a, $urandom, op != 1, op != 0, $urandom_range(0, 3), $urandom_range(0, 3));
        end
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        #1;
        check("rand_hit_count", hit_count_o, exp_hits);
        check("rand_miss_count", miss_count_o, exp_misses);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
